alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  requester n's operation accepted this cycle.
REQ-006 req0_op / req1_op  input  3 each  ALU control code.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH each  operands.
REQ-008 rsp_valid  output  1  result register holds a valid result.
REQ-009 rsp_ready  input  1  consumer takes the result this cycle.
REQ-010 rsp_id  output  1  requester that issued the held result.
REQ-011 rsp_result  output  WIDTH  ALU result, low WIDTH bits.
REQ-012 rsp_carry  output  1  carry/borrow out; 0 for non-arithmetic ops.
REQ-013 rsp_zero  output  1  1 when rsp_result is all zeros.

Function
REQ-014 Opcodes: AND=0, SUB=1, ADD=2, OR=3, XOR=4, SHIFT=5, SHIFTSE=6, MUL=7.
REQ-015 Transfer on req_n: req_n_valid && req_n_ready in the same cycle; at most one requester granted per cycle.
REQ-016 Output buffer is one entry with states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 Accept condition: accept = EMPTY || (FULL && rsp_ready); req_n_ready = accept && grant_n, combinational from current state and inputs.
REQ-018 Single valid requester is granted whenever accept=1.
REQ-019 Both valid: grant goes to the requester not recorded in last_grant; last_grant updates on every transfer.
REQ-020 Fairness: a continuously-valid requester waits at most one transfer of the other requester.
REQ-021 Latency: operation transferred in cycle N appears on rsp_* with rsp_valid=1 in cycle N+1.
REQ-022 Transitions: EMPTY->FULL on transfer; FULL->EMPTY on rsp_ready without transfer; FULL stays FULL on rsp_ready with transfer (back-to-back, no bubble); FULL holds on !rsp_ready.
REQ-023 While FULL && !rsp_ready, all rsp_* outputs are held stable and both req_ready are 0.
REQ-024 ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum; SUB: result = a-b, carry = 1 when a<b (borrow).
REQ-025 SHIFT: b interpreted as signed; b>=0 logical left by b, b<0 logical right by |b|; SHIFTSE identical but right shift is arithmetic; shift amounts >=WIDTH yield 0 (or all sign bits for SHIFTSE right).
REQ-026 MUL: low WIDTH bits of unsigned product; carry = 1 when the high WIDTH bits are non-zero.
REQ-027 AND/OR/XOR: carry = 0.
REQ-028 Operands are sampled only in the transfer cycle; later changes on req_* do not affect the held result.
REQ-029 Requester inputs with valid=0 are ignored regardless of op/operand values.

Reset
REQ-030 Asserting reset in any cycle, including mid-hold, immediately forces EMPTY: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_zero=0; the held result is discarded.
REQ-031 Reset sets last_grant=1, so requester 0 wins the first conflict.
REQ-032 While reset is high, req0_ready=req1_ready=0.

Structure
REQ-033 Opcode constants and WIDTH default reside in shared package alu_pkg, used by alu, alu_arbiter and benches.
REQ-034 Datapath is one instance of combinational sub-module alu fed by the grant mux; arbiter contains only mux, grant logic, state and result register.

Verification
REQ-035 Reset release, req0 ADD 255+1, rsp_ready=1 -> next cycle rsp_valid=1, id=0, result=0, carry=1, zero=1.
REQ-036 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 with one response per cycle, no bubble.
REQ-037 rsp_ready=0 for 3 cycles after req1 SUB 3-5 -> result=254, carry=1 held stable, both ready=0; drain -> next transfer accepted same cycle.
REQ-038 SHIFTSE a=0x80, b=-3 -> result=0xF0; SHIFT a=0x81, b=1 -> 0x02, carry=0.
REQ-039 MUL 16*16 -> result=0, carry=1, zero=1; MUL 15*17 -> 255, carry=0.
REQ-040 Reset asserted while FULL -> rsp_valid drops without waiting for clk; first post-reset conflict grants requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding, default datapath width and buffer states for the
// ALU arbiter slice.
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   typedef enum logic [2:0] {
      OP_AND     = 3'd0,
      OP_SUB     = 3'd1,
      OP_ADD     = 3'd2,
      OP_OR      = 3'd3,
      OP_XOR     = 3'd4,
      OP_SHIFT   = 3'd5,
      OP_SHIFTSE = 3'd6,
      OP_MUL     = 3'd7
   } alu_op_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: logic ops, add/sub with carry/borrow, signed-amount
// shifts and a truncating unsigned multiply with overflow flag.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     dif;
   logic [2*WIDTH-1:0] prod;
   logic               neg;
   logic [WIDTH-1:0]   mag;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign dif  = {1'b0, a} - {1'b0, b};
   assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // b is a signed shift amount; |b| is carried unsigned so -2^(W-1) still fits.
   // Native shifts already give 0 / sign fill for amounts >= WIDTH.
   assign neg = b[WIDTH-1];
   assign mag = neg ? (~b + 1'b1) : b;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_AND:  result = a & b;
         OP_SUB: begin
            result = dif[WIDTH-1:0];
            carry  = dif[WIDTH];
         end
         OP_ADD: begin
            result = sum[WIDTH-1:0];
            carry  = sum[WIDTH];
         end
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_SHIFT: begin
            if (neg) result = a >> mag;
            else     result = a << mag;
         end
         OP_SHIFTSE: begin
            if (neg) result = $signed(a) >>> mag;
            else     result = a << mag;
         end
         OP_MUL: begin
            result = prod[WIDTH-1:0];
            carry  = |prod[2*WIDTH-1:WIDTH];
         end
         default: begin
            result = '0;
            carry  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU with a one-entry
// result register; back-to-back transfers sustain one result per cycle.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_zero
);

   buf_state_e       state_q, state_d;
   logic             last_grant_q;
   logic             accept;
   logic             grant0, grant1;
   logic             xfer;
   logic [2:0]       mux_op;
   logic [WIDTH-1:0] mux_a, mux_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;

   // Ties go to whichever requester did not win the previous transfer.
   assign grant0 = req0_valid && (!req1_valid || last_grant_q);
   assign grant1 = req1_valid && !grant0;

   assign mux_op = grant1 ? req1_op : req0_op;
   assign mux_a  = grant1 ? req1_a  : req0_a;
   assign mux_b  = grant1 ? req1_b  : req0_b;

   alu #(.WIDTH(WIDTH)) u_alu (
      .op     (mux_op),
      .a      (mux_a),
      .b      (mux_b),
      .result (alu_result),
      .carry  (alu_carry)
   );

   always_comb begin
      state_d    = state_q;
      accept     = (state_q == ST_EMPTY) || rsp_ready;
      // reset is asynchronous, so readies are masked directly rather than
      // relying on the state register alone.
      req0_ready = !reset && accept && grant0;
      req1_ready = !reset && accept && grant1;
      xfer       = req0_ready || req1_ready;
      if (xfer)           state_d = ST_FULL;
      else if (rsp_ready) state_d = ST_EMPTY;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_EMPTY;
         last_grant_q <= 1'b1;
      end else begin
         state_q <= state_d;
         if (xfer) last_grant_q <= grant1;
      end
   end

   // Result register loads only on a transfer, so it is frozen while held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_id     <= 1'b0;
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_zero   <= 1'b0;
      end else if (xfer) begin
         rsp_id     <= grant1;
         rsp_result <= alu_result;
         rsp_carry  <= alu_carry;
         rsp_zero   <= (alu_result == '0);
      end
   end

   assign rsp_valid = (state_q == ST_FULL);

endmodule
